// File: rtl/rx_fsm_pkg.sv
// Shared UART receive definitions: state encoding, frame geometry, timer helpers.
// Frame length depends on RX_PARITY_EN (adds an even-parity bit after the data byte).
package rx_fsm_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

`ifdef RX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned LAST_BIT   = 8;
`else
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned LAST_BIT   = 7;
`endif

  // Offset from the first low cycle to the mid-bit sample point.
  function automatic int unsigned half_bit(input int unsigned clks);
    return (clks - 1) / 2;
  endfunction

  function automatic int unsigned timer_width(input int unsigned clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/rx_fsm_bit_timer.sv
// Down-counting sample timer: ticks while the count is zero, reloads on request.
// With CLKS_PER_BIT=1 the tick is constant and the counter folds away.
module rx_bit_timer
  import rx_fsm_pkg::*;
#(
  parameter  int unsigned CLKS_PER_BIT = 1,
  localparam int unsigned TW           = timer_width(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          tick
);

  localparam logic [TW-1:0] RST_VAL = TW'(half_bit(CLKS_PER_BIT));

  logic [TW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    tick = (CLKS_PER_BIT == 1) ? 1'b1 : (cnt == '0);
  end

endmodule

// File: rtl/rx_fsm.sv
// UART receiver: start, 8 data bits LSB first, optional even parity, stop.
// Optional parity bit enabled by defining RX_PARITY_EN (must match the transmitter).
module rx_fsm
  import rx_fsm_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic [1:0]        s
);

  localparam int unsigned TW = timer_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_VAL = TW'(half_bit(CLKS_PER_BIT));
  localparam logic [TW-1:0] FULL_VAL = TW'(CLKS_PER_BIT - 1);

  rx_state_e          state, nstate;
  logic               tick;
  logic               tmr_load;
  logic [TW-1:0]      tmr_val;
  logic               detect;
  logic               good;
  logic               bad;
  logic               par_bad;
  logic               armed;
  logic [CNT_W-1:0]   bitcnt;
  logic [DATA_W-1:0]  shift;
`ifdef RX_PARITY_EN
  logic               par;
`endif

  rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nstate;
  end

  // In IDLE the timer is parked at the half-bit offset, so a tick there means
  // the start bit is checked in the detection cycle itself.
  always_comb begin
    detect = (state == ST_IDLE) && armed && !rxd;
    nstate = state;
    unique case (state)
      ST_IDLE:  if (detect) nstate = tick ? ST_DATA : ST_START;
      ST_START: if (tick) nstate = rxd ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tick && (bitcnt == CNT_W'(LAST_BIT))) nstate = ST_STOP;
      ST_STOP:  if (tick) nstate = ST_IDLE;
      default:  nstate = ST_IDLE;
    endcase
    tmr_load = tick || ((state == ST_IDLE) && !detect);
    tmr_val  = (nstate == ST_IDLE) ? HALF_VAL : FULL_VAL;
  end

  always_comb begin
    s = state;
`ifdef RX_PARITY_EN
    par_bad = par;
`else
    par_bad = 1'b0;
`endif
    good = (state == ST_STOP) && tick && rxd && !par_bad;
    bad  = (state == ST_STOP) && tick && (!rxd || par_bad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      shift     <= '0;
      bitcnt    <= '0;
      armed     <= 1'b0;
`ifdef RX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      valid     <= good;
      frame_err <= bad;
      if (good) data <= shift;

      // A stop bit sampled low is a break: wait for the line to go high again.
      if ((state == ST_IDLE) && rxd) armed <= 1'b1;
      else if (bad && !rxd)          armed <= 1'b0;

      if ((state == ST_DATA) && tick) begin
        if (bitcnt < CNT_W'(DATA_W)) shift <= {rxd, shift[DATA_W-1:1]};
        bitcnt <= (bitcnt == CNT_W'(LAST_BIT)) ? '0 : bitcnt + 1'b1;
`ifdef RX_PARITY_EN
        par    <= par ^ rxd;
`endif
      end
`ifdef RX_PARITY_EN
      if (detect) par <= 1'b0;
`endif
    end
  end

endmodule
